// File: rtl/pingpong_scheduler.sv
// Ping-pong frame scheduler: splits a frame into packets of beats and steers each
// group of PP_GROUP packets alternately to OUT1/OUT2, generating TKEEP/TLAST per beat.
module pingpong_scheduler #(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     FRAME_SIZE,
  input  logic [31:0]     PACKET_SIZE,
  input  logic [31:0]     PP_GROUP,
  input  logic            start,
  input  logic            beat_fire,
  output logic            busy,
  output logic            route_sel,
  output logic [DW/8-1:0] beat_keep,
  output logic            beat_last,
  output logic            frame_done,
  output logic            cfg_err,
  output logic [31:0]     pkt_count,
  output logic [1:0]      dbg_state
);

  localparam int          KW         = DW / 8;
  localparam logic [31:0] BEAT_BYTES = 32'(KW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: beat_fire is the already-qualified TVALID & TREADY of the switch
  // input; every output describing the current beat is a function of registered
  // state only, so it is stable for the whole cycle the beat is offered.
  state_t      state_q, state_d;
  logic [31:0] packet_q, packet_d;
  logic [31:0] pp_group_q, pp_group_d;
  logic [31:0] frame_rem_q, frame_rem_d;
  logic [31:0] pkt_rem_q, pkt_rem_d;
  logic [31:0] grp_cnt_q, grp_cnt_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic        route_sel_q, route_sel_d;
  logic        cfg_err_q, cfg_err_d;
  logic [31:0] frame_after;

  always_comb begin
    state_d     = state_q;
    packet_d    = packet_q;
    pp_group_d  = pp_group_q;
    frame_rem_d = frame_rem_q;
    pkt_rem_d   = pkt_rem_q;
    grp_cnt_d   = grp_cnt_q;
    pkt_count_d = pkt_count_q;
    route_sel_d = route_sel_q;
    cfg_err_d   = 1'b0;
    frame_after = frame_rem_q - pkt_rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((FRAME_SIZE != 32'd0) && (PACKET_SIZE != 32'd0) && (PP_GROUP != 32'd0)) begin
            packet_d    = PACKET_SIZE;
            pp_group_d  = PP_GROUP;
            frame_rem_d = FRAME_SIZE;
            pkt_rem_d   = (PACKET_SIZE < FRAME_SIZE) ? PACKET_SIZE : FRAME_SIZE;
            grp_cnt_d   = 32'd0;
            pkt_count_d = 32'd0;
            route_sel_d = 1'b0;
            state_d     = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (beat_fire) begin
          if (pkt_rem_q > BEAT_BYTES) begin
            pkt_rem_d   = pkt_rem_q - BEAT_BYTES;
            frame_rem_d = frame_rem_q - BEAT_BYTES;
          end else begin
            // frame_rem >= pkt_rem always holds, so frame_after cannot wrap
            frame_rem_d = frame_after;
            pkt_rem_d   = (packet_q < frame_after) ? packet_q : frame_after;
            pkt_count_d = pkt_count_q + 32'd1;
            if (grp_cnt_q + 32'd1 == pp_group_q) begin
              grp_cnt_d   = 32'd0;
              route_sel_d = ~route_sel_q;
            end else begin
              grp_cnt_d = grp_cnt_q + 32'd1;
            end
            if (frame_after == 32'd0) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      packet_q    <= 32'd0;
      pp_group_q  <= 32'd0;
      frame_rem_q <= 32'd0;
      pkt_rem_q   <= 32'd0;
      grp_cnt_q   <= 32'd0;
      pkt_count_q <= 32'd0;
      route_sel_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      packet_q    <= packet_d;
      pp_group_q  <= pp_group_d;
      frame_rem_q <= frame_rem_d;
      pkt_rem_q   <= pkt_rem_d;
      grp_cnt_q   <= grp_cnt_d;
      pkt_count_q <= pkt_count_d;
      route_sel_q <= route_sel_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    beat_keep = '0;
    for (int i = 0; i < KW; i++) begin
      beat_keep[i] = (state_q == RUN) && (32'(i) < pkt_rem_q);
    end
  end

  assign busy       = (state_q != IDLE);
  assign route_sel  = route_sel_q;
  assign beat_last  = (state_q == RUN) && (pkt_rem_q <= BEAT_BYTES);
  assign frame_done = (state_q == DONE);
  assign cfg_err    = cfg_err_q;
  assign pkt_count  = pkt_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pingpong_scheduler.sv
// Directed bench for pingpong_scheduler: expected beats are queued per frame and
// compared as the scheduler presents them.
module tb_pingpong_scheduler;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   frame_size = 32'd0;
  logic [31:0]   packet_size = 32'd0;
  logic [31:0]   pp_group = 32'd0;
  logic          start = 1'b0;
  logic          beat_fire = 1'b0;
  logic          busy;
  logic          route_sel;
  logic [KW-1:0] beat_keep;
  logic          beat_last;
  logic          frame_done;
  logic          cfg_err;
  logic [31:0]   pkt_count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // {route_sel, beat_last, beat_keep}
  logic [KW+1:0] exp_q[$];

  pingpong_scheduler #(.DW(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .FRAME_SIZE (frame_size),
    .PACKET_SIZE(packet_size),
    .PP_GROUP   (pp_group),
    .start      (start),
    .beat_fire  (beat_fire),
    .busy       (busy),
    .route_sel  (route_sel),
    .beat_keep  (beat_keep),
    .beat_last  (beat_last),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .pkt_count  (pkt_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] keep_of(input int nbytes);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < KW; i++) if (i < nbytes) k[i] = 1'b1;
    return k;
  endfunction

  task automatic push_beat(input logic sel, input int nbytes, input logic last);
    exp_q.push_back({sel, last, keep_of(nbytes)});
  endtask

  task automatic do_start(input int f, input int p, input int g);
    frame_size  = 32'(f);
    packet_size = 32'(p);
    pp_group    = 32'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [KW+1:0] e, input int pkts);
    chk({tag, ".sel"},   64'(route_sel), 64'(e[KW+1]));
    chk({tag, ".last"},  64'(beat_last), 64'(e[KW]));
    chk({tag, ".keep"},  64'(beat_keep), 64'(e[KW-1:0]));
    chk({tag, ".busy"},  64'(busy), 64'd1);
    chk({tag, ".pkts"},  64'(pkt_count), 64'(pkts));
    chk({tag, ".done"},  64'(frame_done), 64'd0);
  endtask

  // Fires n queued beats; with gaps, idle cycles carrying a spurious start come first.
  task automatic fire_beats(input string tag, input int n, input bit gaps);
    logic [KW+1:0] e;
    int pkts;
    pkts = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL %s.queue observed=empty expected=beat", tag);
        return;
      end
      e = exp_q.pop_front();
      check_beat(tag, e, pkts);
      if (gaps) begin
        repeat ($urandom_range(1, 3)) begin
          frame_size = $urandom_range(1, 4096);
          start = 1'b1;
          tick();
          start = 1'b0;
          check_beat({tag, ".gap"}, e, pkts);
        end
      end
      beat_fire = 1'b1;
      tick();
      beat_fire = 1'b0;
      if (e[KW]) pkts++;
    end
  endtask

  task automatic run_frame(input string tag, input int n, input bit gaps, input int exp_pkts);
    fire_beats(tag, n, gaps);
    chk({tag, ".fdone"},  64'(frame_done), 64'd1);
    chk({tag, ".fstate"}, 64'(dbg_state), 64'd2);
    chk({tag, ".fpkts"},  64'(pkt_count), 64'(exp_pkts));
    chk({tag, ".fbusy"},  64'(busy), 64'd1);
    beat_fire = 1'b1;
    tick();
    beat_fire = 1'b0;
    chk({tag, ".pulse"},  64'(frame_done), 64'd0);
    chk({tag, ".idle"},   64'(busy), 64'd0);
    chk({tag, ".istate"}, 64'(dbg_state), 64'd0);
    chk({tag, ".hold"},   64'(pkt_count), 64'(exp_pkts));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},  64'(busy), 64'd0);
    chk({tag, ".sel"},   64'(route_sel), 64'd0);
    chk({tag, ".keep"},  64'(beat_keep), 64'd0);
    chk({tag, ".last"},  64'(beat_last), 64'd0);
    chk({tag, ".done"},  64'(frame_done), 64'd0);
    chk({tag, ".err"},   64'(cfg_err), 64'd0);
    chk({tag, ".pkts"},  64'(pkt_count), 64'd0);
    chk({tag, ".state"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic push_basic();
    push_beat(1'b0, 64, 1'b0);
    push_beat(1'b0, 64, 1'b1);
    push_beat(1'b1, 64, 1'b0);
    push_beat(1'b1, 64, 1'b1);
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    tick();
    resetn = 1'b1;
    tick();
    check_all_zero("post_reset");

    // FRAME=256 PACKET=128 PP_GROUP=1
    push_basic();
    do_start(256, 128, 1);
    chk("basic.state", 64'(dbg_state), 64'd1);
    run_frame("basic", 4, 1'b0, 2);

    // FRAME=300 PACKET=100 PP_GROUP=2
    for (int p = 0; p < 3; p++) begin
      push_beat((p == 2), 64, 1'b0);
      push_beat((p == 2), 36, 1'b1);
    end
    do_start(300, 100, 2);
    run_frame("odd", 6, 1'b0, 3);

    // FRAME=200 PACKET=128 PP_GROUP=4: short final packet
    push_beat(1'b0, 64, 1'b0);
    push_beat(1'b0, 64, 1'b1);
    push_beat(1'b0, 64, 1'b0);
    push_beat(1'b0, 8, 1'b1);
    do_start(200, 128, 4);
    run_frame("short", 4, 1'b0, 2);

    // PACKET > FRAME: a single 100-byte packet
    push_beat(1'b0, 64, 1'b0);
    push_beat(1'b0, 36, 1'b1);
    do_start(100, 1000, 1);
    run_frame("big_pkt", 2, 1'b0, 1);

    // illegal configuration
    do_start(256, 128, 0);
    chk("cfg.err", 64'(cfg_err), 64'd1);
    chk("cfg.busy", 64'(busy), 64'd0);
    beat_fire = 1'b1;
    tick();
    chk("cfg.pulse", 64'(cfg_err), 64'd0);
    tick();
    beat_fire = 1'b0;
    chk("cfg.busy2", 64'(busy), 64'd0);
    chk("cfg.pkts", 64'(pkt_count), 64'd1);
    chk("cfg.keep", 64'(beat_keep), 64'd0);
    do_start(0, 128, 1);
    chk("cfg.frame0", 64'(cfg_err), 64'd1);
    do_start(256, 0, 1);
    chk("cfg.pkt0", 64'(cfg_err), 64'd1);
    tick();
    chk("cfg.state", 64'(dbg_state), 64'd0);

    // idle cycles and a second start while running
    push_basic();
    do_start(256, 128, 1);
    run_frame("gaps", 4, 1'b1, 2);

    // reset mid-frame, then the same frame from the top
    push_basic();
    do_start(256, 128, 1);
    fire_beats("abort", 2, 1'b0);
    exp_q.delete();
    resetn = 1'b0;
    #1;
    check_all_zero("abort_rst");
    tick();
    chk("abort.nodone", 64'(frame_done), 64'd0);
    resetn = 1'b1;
    tick();
    chk("abort.nodone2", 64'(frame_done), 64'd0);
    chk("abort.idle", 64'(busy), 64'd0);
    push_basic();
    do_start(256, 128, 1);
    run_frame("restart", 4, 1'b0, 2);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpong_scheduler.md
PINGPONG_SCHEDULER -- requirements
Module: pingpong_scheduler

Interface
REQ-001: Parameter DW, default 512, data beat width in bits of the switched stream; beat size B = DW/8 bytes.
REQ-002: clk  input  1  single clock; all logic is synchronous to the rising edge.
REQ-003: resetn  input  1  asynchronous, active-low reset.
REQ-004: FRAME_SIZE  input  32  frame length in bytes, sampled on accepted start.
REQ-005: PACKET_SIZE  input  32  packet length in bytes, sampled on accepted start.
REQ-006: PP_GROUP  input  32  packets per ping-pong group, sampled on accepted start.
REQ-007: start  input  1  one-cycle request to begin scheduling a frame.
REQ-008: beat_fire  input  1  one beat transferred on the switch input (TVALID & TREADY).
REQ-009: busy  output  1  high while a frame is being scheduled.
REQ-010: route_sel  output  1  destination of the current beat: 0 = OUT1, 1 = OUT2.
REQ-011: beat_keep  output  DW/8  byte-enable for the current beat, LSB-aligned.
REQ-012: beat_last  output  1  current beat is the last beat of its packet (drives TLAST).
REQ-013: frame_done  output  1  one-cycle pulse after the final beat of a frame.
REQ-014: cfg_err  output  1  one-cycle pulse when start is rejected for illegal configuration.
REQ-015: pkt_count  output  32  packets completed in the current frame.

Function
REQ-016: The FSM SHALL have states IDLE, RUN and DONE.
REQ-017: IDLE -> RUN on start when FRAME_SIZE, PACKET_SIZE and PP_GROUP are all non-zero; the three values, frame_rem = FRAME_SIZE and pkt_rem = min(PACKET_SIZE, FRAME_SIZE) SHALL be latched.
REQ-018: In IDLE, start with any of the three values equal to zero SHALL assert cfg_err for exactly one cycle and stay in IDLE.
REQ-019: RUN SHALL be entered the cycle after the accepted start, with route_sel = 0, pkt_count = 0 and the group counter = 0; outputs for beat 0 are valid in that cycle.
REQ-020: route_sel, beat_keep and beat_last SHALL depend only on registered state, never combinationally on beat_fire.
REQ-021: beat_keep SHALL have its low min(B, pkt_rem) bits set and all others clear; beat_last = (pkt_rem <= B).
REQ-022: On beat_fire in RUN with pkt_rem > B: pkt_rem -= B and frame_rem -= B.
REQ-023: On beat_fire in RUN with pkt_rem <= B: frame_rem -= pkt_rem, pkt_count += 1, and the next pkt_rem = min(PACKET_SIZE, remaining frame bytes).
REQ-024: The group counter SHALL increment at each packet end; when it reaches PP_GROUP it SHALL clear and route_sel SHALL toggle, taking effect on the first beat of the next packet.
REQ-025: A packet end that leaves frame_rem = 0 SHALL move the FSM to DONE; DONE asserts frame_done for one cycle, then returns to IDLE.
REQ-026: busy = 1 in RUN and DONE, and 0 in IDLE.
REQ-027: beat_fire in IDLE or DONE SHALL be ignored, and start in RUN or DONE SHALL be ignored.
REQ-028: A final packet shorter than PACKET_SIZE (FRAME_SIZE not a multiple of PACKET_SIZE) SHALL end on frame_rem, with a partial beat_keep.
REQ-029: All byte arithmetic SHALL be 32-bit unsigned and must not underflow; PACKET_SIZE > FRAME_SIZE yields one packet of FRAME_SIZE bytes.

Reset
REQ-030: While resetn = 0, the state SHALL be IDLE; busy, route_sel, beat_last, frame_done and cfg_err SHALL be 0, and beat_keep, pkt_count and all counters SHALL be 0.
REQ-031: Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done pulse.

Verification
REQ-032: DW=512, FRAME=256, PACKET=128, PP_GROUP=1, 4 beat_fire -> sel 0,0,1,1; beat_last on beats 1 and 3; keep all-ones; frame_done pulse after beat 3; pkt_count = 2.
REQ-033: FRAME=300, PACKET=100, PP_GROUP=2 -> six beats with keep 64/36 bytes alternating and beat_last on beats 1, 3 and 5; sel 0,0,0,0,1,1; pkt_count = 3.
REQ-034: FRAME=200, PACKET=128, PP_GROUP=4 -> beats 64, 64(last), 64, 8(last, keep = 0xFF); sel stays 0; frame_done after beat 3.
REQ-035: start with PP_GROUP=0 -> cfg_err high for one cycle; busy stays 0; subsequent beat_fire has no effect.
REQ-036: Second start and idle-cycle beat_fire during RUN -> the second start is ignored, and no counter changes occur in cycles without beat_fire.
REQ-037: resetn pulsed low after beat 1 of the REQ-032 frame -> all outputs 0 and no frame_done; a new start then reproduces the REQ-032 sequence from beat 0.
